config_loader: RTL and testbench
================================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter WORD_WIDTH, default 8: bitstream word width in bits.
REQ-002 Parameter CHAIN_LEN, default 160: total scan-chain length in bits; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle request to begin a load.
REQ-006 word_in  input  WORD_WIDTH  bitstream word, shifted LSB first.
REQ-007 word_valid  input  1  word_in is valid.
REQ-008 word_ready  output  1  loader accepts word_in this cycle.
REQ-009 scan_out  output  1  serial data to the fabric chain scan_in.
REQ-010 scan_en  output  1  fabric chain shift enable.
REQ-011 busy  output  1  load in progress.
REQ-012 done  output  1  full chain loaded; held until next accepted start.
REQ-013 err  output  1  sticky parity error (CFG_PARITY_EN only; otherwise tied 0).
REQ-014 word_par  input  1  even parity of word_in (present only with CFG_PARITY_EN).

Function
REQ-015 FSM states SHALL be IDLE, FETCH, SHIFT and DONE.
REQ-016 IDLE/DONE + start=1 -> FETCH; clear done, err and bit counter.
REQ-017 start while busy SHALL be ignored.
REQ-018 word_ready SHALL be 1 only in FETCH.
REQ-019 Transfer occurs on a cycle with word_valid=1 and word_ready=1; word_in is latched into the shift register and the FSM moves to SHIFT.
REQ-020 In SHIFT: scan_en=1 every cycle; scan_out = shift-register bit 0; register shifts right by one per cycle.
REQ-021 First bit of an accepted word SHALL appear on scan_out with scan_en=1 the cycle after the transfer.
REQ-022 Each SHIFT visit SHALL last min(WORD_WIDTH, CHAIN_LEN - bits_shifted) cycles; surplus high bits of the final word SHALL be discarded.
REQ-023 Bit counter SHALL be ceil(log2(CHAIN_LEN+1)) bits wide and SHALL never exceed CHAIN_LEN.
REQ-024 After the last bit of a word: counter < CHAIN_LEN -> FETCH; counter == CHAIN_LEN -> DONE.
REQ-025 Words required per load = ceil(CHAIN_LEN/WORD_WIDTH); total scan_en-high cycles = exactly CHAIN_LEN.
REQ-026 scan_en SHALL be 0 in IDLE, FETCH and DONE; the chain SHALL hold while waiting on word_valid.
REQ-027 scan_out SHALL be 0 whenever scan_en=0.
REQ-028 busy SHALL be 1 in FETCH and SHIFT, 0 otherwise.
REQ-029 done SHALL rise the cycle after the final shift cycle.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, with scan_en, scan_out, word_ready, busy, done and err = 0 and counter and shift register = 0.
REQ-031 Reset mid-load SHALL abort without further shifting; the partial chain content is undefined and a new start is required.
REQ-032 Release of rst_n SHALL NOT start a load.

Configuration
REQ-033 Macro CFG_PARITY_EN SHALL compile in the word_par port and parity checking.
REQ-034 With CFG_PARITY_EN defined: on transfer, if XOR(word_in) != word_par, then set err, do not shift the word, and go to IDLE with busy=0 and done=0.
REQ-035 With CFG_PARITY_EN defined: err SHALL stay set until reset or the next accepted start.
REQ-036 Without CFG_PARITY_EN: word_par SHALL be absent, err SHALL be constant 0, and no parity logic SHALL exist.

Verification (WORD_WIDTH=8, CHAIN_LEN=20)
REQ-037 Load: start, then words 0xA5, 0x3C, 0x0F with word_valid always 1 -> scan_out = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1; exactly 20 scan_en cycles; done the cycle after.
REQ-038 Backpressure: word_valid held 0 for 5 cycles before word 2 -> scan_en=0 and word_ready=1 during the gap; bit sequence unchanged; 20 scan_en cycles total.
REQ-039 Start while busy: start pulsed during the first word's SHIFT -> no restart; done after the same total of 20 shift cycles.
REQ-040 Mid-load reset: rst_n=0 after 10 shift cycles -> all outputs 0 that cycle; a fresh start then reloads all 20 bits correctly.
REQ-041 Parity (CFG_PARITY_EN): second word 0x3C with word_par=1 -> err=1, busy=0, done=0, only 8 scan_en cycles total.
REQ-042 Restart from DONE: start while done=1 -> done clears the next cycle and a second full 20-bit load completes.

Source files
------------

// File: rtl/config_loader.sv
// config_loader: streams bitstream words LSB-first into a fabric scan chain.
// Build option: `define CFG_PARITY_EN adds the word_par port and the sticky parity error.
module config_loader #(
  parameter int WORD_WIDTH = 8,
  parameter int CHAIN_LEN  = 160
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
`ifdef CFG_PARITY_EN
  input  logic                  word_par,
`endif
  output logic                  word_ready,
  output logic                  scan_out,
  output logic                  scan_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  // state | meaning
  // IDLE  | no load pending; waits for start
  // FETCH | waiting on word_valid; chain holds
  // SHIFT | presenting one word's bits on scan_out, one per cycle
  // DONE  | whole chain loaded; done held until the next start

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int LW = $clog2(WORD_WIDTH + 1);
  localparam logic [CW-1:0] CHAIN_END = CW'(CHAIN_LEN);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         bit_cnt;
  logic [LW-1:0]         word_left;
  logic [WORD_WIDTH-1:0] shift_reg;
  logic [WORD_WIDTH-1:0] shift_nxt;
  logic [CW-1:0]         cnt_nxt;
  logic [LW-1:0]         word_bits;

  // The final word may be only partially used; its surplus high bits never shift out.
  always_comb begin
    shift_nxt = shift_reg >> 1;
    cnt_nxt   = bit_cnt + CW'(1);
    if ((CHAIN_LEN - int'(bit_cnt)) < WORD_WIDTH)
      word_bits = LW'(CHAIN_LEN - int'(bit_cnt));
    else
      word_bits = LW'(WORD_WIDTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      word_left  <= '0;
      shift_reg  <= '0;
      word_ready <= 1'b0;
      scan_out   <= 1'b0;
      scan_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef CFG_PARITY_EN
      err        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= FETCH;
            bit_cnt    <= '0;
            word_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
`ifdef CFG_PARITY_EN
            err        <= 1'b0;
`endif
          end
        end
        FETCH: begin
          if (word_valid) begin
`ifdef CFG_PARITY_EN
            if ((^word_in) != word_par) begin
              state      <= IDLE;
              err        <= 1'b1;
              word_ready <= 1'b0;
              busy       <= 1'b0;
            end else
`endif
            begin
              state      <= SHIFT;
              shift_reg  <= word_in;
              word_left  <= word_bits;
              word_ready <= 1'b0;
              scan_en    <= 1'b1;
              scan_out   <= word_in[0];
            end
          end
        end
        SHIFT: begin
          bit_cnt <= cnt_nxt;
          if (word_left == LW'(1)) begin
            scan_en  <= 1'b0;
            scan_out <= 1'b0;
            if (cnt_nxt == CHAIN_END) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state      <= FETCH;
              word_ready <= 1'b1;
            end
          end else begin
            word_left <= word_left - LW'(1);
            shift_reg <= shift_nxt;
            scan_out  <= shift_nxt[0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef CFG_PARITY_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Randomized self-checking bench for config_loader (WORD_WIDTH=8, CHAIN_LEN=20).
module tb_config_loader;
  localparam int WW = 8;
  localparam int CL = 20;
  localparam int NW = (CL + WW - 1) / WW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [WW-1:0] word_in = '0;
  logic          word_valid = 1'b0;
`ifdef CFG_PARITY_EN
  logic          word_par = 1'b0;
`endif
  logic          word_ready, scan_out, scan_en, busy, done, err;

  config_loader #(.WORD_WIDTH(WW), .CHAIN_LEN(CL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_in(word_in),
    .word_valid(word_valid),
`ifdef CFG_PARITY_EN
    .word_par(word_par),
`endif
    .word_ready(word_ready), .scan_out(scan_out), .scan_en(scan_en),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_en = -1;
  int done_rise = -1;
  bit prev_done = 1'b0;
  bit obs[$];
  logic [WW-1:0] wq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and record what the chain saw.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (scan_en) begin
      obs.push_back(scan_out);
      last_en = cyc;
    end else begin
      chk("scan_out_low", 32'(scan_out), 0);
    end
    if (!busy) chk("idle_quiet", {30'd0, word_ready, scan_en}, 0);
    if (done && !prev_done) done_rise = cyc;
    prev_done = done;
  endtask

  function automatic bit exp_bit(input int j);
    logic [WW-1:0] w;
    w = wq[j / WW];
    return w[j % WW];
  endfunction

  task automatic new_words();
    wq.delete();
    for (int i = 0; i < NW; i++) wq.push_back(WW'($urandom));
  endtask

  task automatic present_word(input int i);
    word_in = wq[i];
`ifdef CFG_PARITY_EN
    word_par = ^wq[i];
`endif
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    word_in = WW'($urandom);
    chk("first_bit", {30'd0, scan_en, scan_out}, {30'd0, 1'b1, wq[i][0]});
  endtask

  task automatic wait_ready(output bit ok);
    int k = 0;
    while (!word_ready && k < 100) begin
      tick();
      k++;
    end
    chk("ready_wait", 32'(word_ready), 1);
    ok = word_ready;
  endtask

  task automatic check_result();
    int k = 0;
    int n;
    while (!done && k < 100) begin
      tick();
      k++;
    end
    chk("done", 32'(done), 1);
    chk("busy_after", 32'(busy), 0);
    chk("err_after", 32'(err), 0);
    chk("scan_cycles", obs.size(), CL);
    chk("done_latency", done_rise, last_en + 1);
    n = (obs.size() < CL) ? obs.size() : CL;
    for (int j = 0; j < n; j++) chk($sformatf("bit%0d", j), 32'(obs[j]), 32'(exp_bit(j)));
  endtask

  task automatic begin_load();
    obs.delete();
    done_rise = -1;
    last_en = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_done_clr", 32'(done), 0);
    chk("start_busy", 32'(busy), 1);
  endtask

  task automatic run_load(input int gap_idx, input int gap_len, input bit poke_start);
    bit ok;
    begin_load();
    for (int i = 0; i < NW; i++) begin
      wait_ready(ok);
      if (!ok) break;
      if (i == gap_idx) begin
        repeat (gap_len) begin
          tick();
          chk("gap_ready", 32'(word_ready), 1);
          chk("gap_scan_en", 32'(scan_en), 0);
        end
      end
      present_word(i);
      if (poke_start && i == 0) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    check_result();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    repeat (2) tick();
    chk("reset_outs", {26'd0, word_ready, scan_out, scan_en, busy, done, err}, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("no_self_start", {30'd0, busy, word_ready}, 0);

    // Directed load with the reference words.
    wq = '{8'hA5, 8'h3C, 8'h0F};
    run_load(-1, 0, 1'b0);
    // Restart from DONE, backpressure before word 2, then start while busy.
    wq = '{8'hA5, 8'h3C, 8'h0F};
    run_load(1, 5, 1'b0);
    run_load(-1, 0, 1'b1);

    // Mid-load reset after 10 shift cycles.
    new_words();
    begin_load();
    wait_ready(ok);
    present_word(0);
    wait_ready(ok);
    present_word(1);
    for (int k = 0; k < 50 && obs.size() < 10; k++) tick();
    chk("pre_reset_bits", obs.size(), 10);
    rst_n = 1'b0;
    #1;
    chk("reset_midload", {26'd0, word_ready, scan_out, scan_en, busy, done, err}, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_reset_idle", {29'd0, busy, scan_en, done}, 0);
    run_load(-1, 0, 1'b0);

`ifdef CFG_PARITY_EN
    wq = '{8'hA5, 8'h3C, 8'h0F};
    begin_load();
    wait_ready(ok);
    present_word(0);
    wait_ready(ok);
    word_in = 8'h3C;
    word_par = 1'b1;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    chk("par_err", {29'd0, err, busy, done}, 3'b100);
    repeat (4) tick();
    chk("par_scan_cycles", obs.size(), WW);
    chk("par_err_sticky", 32'(err), 1);
    run_load(-1, 0, 1'b0);
`endif

    // Randomized loads with random backpressure and stray starts.
    for (int r = 0; r < 6; r++) begin
      new_words();
      run_load(int'($urandom_range(0, NW)), int'($urandom_range(1, 6)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
